// File: rtl/recepcao_serial_comandos.sv
// 7E2 serial receiver with ASCII command decoding.
// Emits one-cycle pulses for frame status and game commands.
module recepcao_serial_comandos #(
  parameter int CLKS_PER_BIT = 434,
  parameter int HALF_BIT     = 217
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       entrada_serial,
  output logic [6:0] dado,
  output logic       pronto,
  output logic       erro_paridade,
  output logic       erro_stop,
  output logic       cmd_start,
  output logic       cmd_pause,
  output logic       cmd_restart,
  output logic       cmd_esq,
  output logic       cmd_dir,
  output logic [3:0] db_estado
);

  typedef enum logic [2:0] {
    OCIOSO   = 3'd0,
    INICIO   = 3'd1,
    DADOS    = 3'd2,
    PARIDADE = 3'd3,
    STOP1    = 3'd4,
    STOP2    = 3'd5,
    VALIDA   = 3'd6
  } estado_t;

  localparam logic [8:0] TICK_BIT  = 9'(CLKS_PER_BIT - 1);
  localparam logic [8:0] TICK_MEIO = 9'(HALF_BIT - 1);

  estado_t    estado, estado_n;
  logic [8:0] tick, tick_n;
  logic [2:0] idx, idx_n;
  logic [6:0] shift, shift_n;
  logic [6:0] dado_q, dado_q_n;
  logic       par_err, par_err_n;
  logic       stop_err, stop_err_n;
  logic       armed, armed_n;
  logic       sync_a, rx;
  logic       fim_bit;
  logic       valido;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_a <= 1'b1;
      rx     <= 1'b1;
    end else begin
      sync_a <= entrada_serial;
      rx     <= sync_a;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado   <= OCIOSO;
      tick     <= '0;
      idx      <= '0;
      shift    <= '0;
      dado_q   <= '0;
      par_err  <= 1'b0;
      stop_err <= 1'b0;
      armed    <= 1'b0;
    end else begin
      estado   <= estado_n;
      tick     <= tick_n;
      idx      <= idx_n;
      shift    <= shift_n;
      dado_q   <= dado_q_n;
      par_err  <= par_err_n;
      stop_err <= stop_err_n;
      armed    <= armed_n;
    end
  end

  assign fim_bit = (tick == TICK_BIT);

  always_comb begin
    estado_n   = estado;
    tick_n     = tick;
    idx_n      = idx;
    shift_n    = shift;
    dado_q_n   = dado_q;
    par_err_n  = par_err;
    stop_err_n = stop_err;
    armed_n    = armed;
    unique case (estado)
      OCIOSO: begin
        // armed keeps a held-low line (break) from re-triggering
        if (rx) begin
          armed_n = 1'b1;
        end else if (armed) begin
          tick_n   = '0;
          armed_n  = 1'b0;
          estado_n = INICIO;
        end
      end
      INICIO: begin
        if (tick == TICK_MEIO) begin
          tick_n = '0;
          if (rx) begin
            estado_n = OCIOSO;
          end else begin
            idx_n      = '0;
            par_err_n  = 1'b0;
            stop_err_n = 1'b0;
            estado_n   = DADOS;
          end
        end else begin
          tick_n = tick + 9'd1;
        end
      end
      DADOS: begin
        if (fim_bit) begin
          tick_n  = '0;
          shift_n = {rx, shift[6:1]};
          idx_n   = idx + 3'd1;
          if (idx == 3'd6) begin
            idx_n    = '0;
            estado_n = PARIDADE;
          end
        end else begin
          tick_n = tick + 9'd1;
        end
      end
      PARIDADE: begin
        if (fim_bit) begin
          tick_n    = '0;
          par_err_n = ^{shift, rx};
          estado_n  = STOP1;
        end else begin
          tick_n = tick + 9'd1;
        end
      end
      STOP1: begin
        if (fim_bit) begin
          tick_n = '0;
          if (!rx) stop_err_n = 1'b1;
          estado_n = STOP2;
        end else begin
          tick_n = tick + 9'd1;
        end
      end
      STOP2: begin
        if (fim_bit) begin
          tick_n = '0;
          if (!rx) stop_err_n = 1'b1;
          estado_n = VALIDA;
        end else begin
          tick_n = tick + 9'd1;
        end
      end
      VALIDA: begin
        tick_n = '0;
        if (!stop_err && !par_err) dado_q_n = shift;
        estado_n = OCIOSO;
      end
      default: estado_n = OCIOSO;
    endcase
  end

  assign valido = (estado == VALIDA) && !stop_err && !par_err;

  assign pronto        = valido;
  assign erro_stop     = (estado == VALIDA) && stop_err;
  assign erro_paridade = (estado == VALIDA) && !stop_err && par_err;
  assign dado          = valido ? shift : dado_q;

  assign cmd_start   = valido && (shift == 7'h49);
  assign cmd_pause   = valido && (shift == 7'h50);
  assign cmd_restart = valido && (shift == 7'h52);
  assign cmd_esq     = valido && (shift == 7'h45);
  assign cmd_dir     = valido && (shift == 7'h44);

  assign db_estado = {1'b0, estado};

endmodule

// File: tb/tb_recepcao_serial_comandos.sv
// Directed bench for the 7E2 command receiver.
// A negedge monitor tallies pulses; each test compares tally deltas.
module tb_recepcao_serial_comandos;

  localparam int CPB = 16;
  localparam int HB  = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       entrada_serial = 1'b1;
  logic [6:0] dado;
  logic       pronto, erro_paridade, erro_stop;
  logic       cmd_start, cmd_pause, cmd_restart, cmd_esq, cmd_dir;
  logic [3:0] db_estado;

  int checks = 0;
  int errors = 0;

  int n_pronto = 0, n_par = 0, n_stop = 0;
  int n_start = 0, n_pause = 0, n_restart = 0, n_esq = 0, n_dir = 0;
  int n_multi = 0;
  int log_n = 0;
  int cmd_log [0:63];
  logic [6:0] dado_pronto = '0;

  recepcao_serial_comandos #(.CLKS_PER_BIT(CPB), .HALF_BIT(HB)) dut (
    .clock          (clock),
    .reset          (reset),
    .entrada_serial (entrada_serial),
    .dado           (dado),
    .pronto         (pronto),
    .erro_paridade  (erro_paridade),
    .erro_stop      (erro_stop),
    .cmd_start      (cmd_start),
    .cmd_pause      (cmd_pause),
    .cmd_restart    (cmd_restart),
    .cmd_esq        (cmd_esq),
    .cmd_dir        (cmd_dir),
    .db_estado      (db_estado)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    int k;
    k = int'(cmd_start) + int'(cmd_pause) + int'(cmd_restart)
      + int'(cmd_esq) + int'(cmd_dir);
    if (k > 1) n_multi++;
    if (pronto) begin
      n_pronto++;
      dado_pronto = dado;
    end
    if (erro_paridade) n_par++;
    if (erro_stop) n_stop++;
    if (cmd_start) begin n_start++; cmd_log[log_n % 64] = 1; log_n++; end
    if (cmd_pause) begin n_pause++; cmd_log[log_n % 64] = 2; log_n++; end
    if (cmd_restart) begin n_restart++; cmd_log[log_n % 64] = 3; log_n++; end
    if (cmd_esq) begin n_esq++; cmd_log[log_n % 64] = 4; log_n++; end
    if (cmd_dir) begin n_dir++; cmd_log[log_n % 64] = 5; log_n++; end
  end

  task automatic send_bit(input logic b);
    entrada_serial = b;
    repeat (CPB) @(posedge clock);
  endtask

  task automatic send_frame(input logic [6:0] d, input logic flip_par,
                            input logic stop2);
    send_bit(1'b0);
    for (int i = 0; i < 7; i++) send_bit(d[i]);
    send_bit((^d) ^ flip_par);
    send_bit(1'b1);
    send_bit(stop2);
  endtask

  task automatic idle(input int n);
    entrada_serial = 1'b1;
    repeat (n) @(posedge clock);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++;
    if (db_estado !== 4'd0 || dado !== 7'h00 || pronto !== 1'b0 ||
        erro_paridade !== 1'b0 || erro_stop !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: estado=%0d dado=%h pronto=%b ep=%b es=%b, want 0",
               db_estado, dado, pronto, erro_paridade, erro_stop);
    end
    checks++;
    if ({cmd_start, cmd_pause, cmd_restart, cmd_esq, cmd_dir} !== 5'b0) begin
      errors++;
      $display("FAIL reset_cmds: got %b want 00000",
               {cmd_start, cmd_pause, cmd_restart, cmd_esq, cmd_dir});
    end
    reset = 1'b0;
    idle(10);
  endtask

  task automatic test_start_cmd;
    int b_p, b_s, b_o;
    b_p = n_pronto; b_s = n_start;
    b_o = n_pause + n_restart + n_esq + n_dir;
    send_frame(7'h49, 1'b0, 1'b1);
    idle(5);
    checks++;
    if (n_pronto - b_p !== 1) begin
      errors++;
      $display("FAIL start_pronto: got %0d pulses want 1", n_pronto - b_p);
    end
    checks++;
    if (dado_pronto !== 7'h49 || dado !== 7'h49) begin
      errors++;
      $display("FAIL start_dado: got %h/%h want 49", dado_pronto, dado);
    end
    checks++;
    if (n_start - b_s !== 1) begin
      errors++;
      $display("FAIL start_cmd: got %0d cycles want 1", n_start - b_s);
    end
    checks++;
    if (n_pause + n_restart + n_esq + n_dir - b_o !== 0) begin
      errors++;
      $display("FAIL start_other_cmds: got %0d want 0",
               n_pause + n_restart + n_esq + n_dir - b_o);
    end
  endtask

  task automatic test_back_to_back;
    int b_p, b_l;
    int exp_codes [4];
    exp_codes = '{2, 3, 4, 5};
    b_p = n_pronto; b_l = log_n;
    send_frame(7'h50, 1'b0, 1'b1);
    send_frame(7'h52, 1'b0, 1'b1);
    send_frame(7'h45, 1'b0, 1'b1);
    send_frame(7'h44, 1'b0, 1'b1);
    idle(5);
    checks++;
    if (n_pronto - b_p !== 4) begin
      errors++;
      $display("FAIL b2b_pronto: got %0d want 4", n_pronto - b_p);
    end
    checks++;
    if (log_n - b_l !== 4) begin
      errors++;
      $display("FAIL b2b_cmd_count: got %0d want 4", log_n - b_l);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (cmd_log[(b_l + i) % 64] !== exp_codes[i]) begin
          errors++;
          $display("FAIL b2b_order[%0d]: got %0d want %0d", i,
                   cmd_log[(b_l + i) % 64], exp_codes[i]);
        end
      end
    end
    checks++;
    if (dado !== 7'h44) begin
      errors++;
      $display("FAIL b2b_dado: got %h want 44", dado);
    end
  endtask

  task automatic test_parity_error;
    int b_p, b_e, b_l;
    b_p = n_pronto; b_e = n_par; b_l = log_n;
    send_frame(7'h50, 1'b1, 1'b1);
    idle(5);
    checks++;
    if (n_par - b_e !== 1) begin
      errors++;
      $display("FAIL par_err_pulse: got %0d want 1", n_par - b_e);
    end
    checks++;
    if (n_pronto - b_p !== 0 || log_n - b_l !== 0) begin
      errors++;
      $display("FAIL par_no_pronto: pronto=%0d cmds=%0d want 0/0",
               n_pronto - b_p, log_n - b_l);
    end
    checks++;
    if (dado !== 7'h44) begin
      errors++;
      $display("FAIL par_dado_hold: got %h want 44", dado);
    end
  endtask

  task automatic test_stop_error;
    int b_s, b_e, b_p, b_q;
    b_s = n_stop; b_e = n_par; b_p = n_pronto; b_q = n_esq;
    send_frame(7'h44, 1'b0, 1'b0);
    idle(2 * CPB);
    checks++;
    if (n_stop - b_s !== 1 || n_par - b_e !== 0) begin
      errors++;
      $display("FAIL stop_err: stop=%0d par=%0d want 1/0",
               n_stop - b_s, n_par - b_e);
    end
    checks++;
    if (n_pronto - b_p !== 0) begin
      errors++;
      $display("FAIL stop_no_pronto: got %0d want 0", n_pronto - b_p);
    end
    send_frame(7'h45, 1'b0, 1'b1);
    idle(5);
    checks++;
    if (n_esq - b_q !== 1 || dado !== 7'h45) begin
      errors++;
      $display("FAIL stop_recover: esq=%0d dado=%h want 1/45",
               n_esq - b_q, dado);
    end
  endtask

  task automatic test_break;
    int b_s, b_p, b_q;
    b_s = n_stop; b_p = n_pronto;
    entrada_serial = 1'b0;
    repeat (14 * CPB) @(posedge clock);
    @(negedge clock);
    checks++;
    if (n_stop - b_s !== 1 || n_pronto - b_p !== 0) begin
      errors++;
      $display("FAIL break_err: stop=%0d pronto=%0d want 1/0",
               n_stop - b_s, n_pronto - b_p);
    end
    checks++;
    if (db_estado !== 4'd0) begin
      errors++;
      $display("FAIL break_wait: estado=%0d want 0", db_estado);
    end
    idle(2 * CPB);
    b_q = n_esq;
    send_frame(7'h45, 1'b0, 1'b1);
    idle(5);
    checks++;
    if (n_esq - b_q !== 1) begin
      errors++;
      $display("FAIL break_recover: esq=%0d want 1", n_esq - b_q);
    end
  endtask

  task automatic test_glitch;
    int b_all;
    b_all = n_pronto + n_par + n_stop + log_n;
    entrada_serial = 1'b0;
    repeat (3) @(posedge clock);
    entrada_serial = 1'b1;
    repeat (4) @(posedge clock);
    @(negedge clock);
    checks++;
    if (db_estado !== 4'd1) begin
      errors++;
      $display("FAIL glitch_inicio: estado=%0d want 1", db_estado);
    end
    repeat (3 * HB) @(posedge clock);
    @(negedge clock);
    checks++;
    if (db_estado !== 4'd0) begin
      errors++;
      $display("FAIL glitch_return: estado=%0d want 0", db_estado);
    end
    checks++;
    if (n_pronto + n_par + n_stop + log_n - b_all !== 0) begin
      errors++;
      $display("FAIL glitch_pulses: got %0d want 0",
               n_pronto + n_par + n_stop + log_n - b_all);
    end
  endtask

  task automatic test_reset_mid_frame;
    int b_all, b_s;
    b_all = n_pronto + n_par + n_stop + log_n;
    entrada_serial = 1'b0;
    repeat (3 * CPB) @(posedge clock);
    @(negedge clock);
    checks++;
    if (db_estado !== 4'd2) begin
      errors++;
      $display("FAIL abort_dados: estado=%0d want 2", db_estado);
    end
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (db_estado !== 4'd0 || dado !== 7'h00) begin
      errors++;
      $display("FAIL abort_reset_state: estado=%0d dado=%h want 0/00",
               db_estado, dado);
    end
    entrada_serial = 1'b1;
    repeat (4) @(posedge clock);
    reset = 1'b0;
    idle(8 * CPB);
    checks++;
    if (n_pronto + n_par + n_stop + log_n - b_all !== 0) begin
      errors++;
      $display("FAIL abort_pulses: got %0d want 0",
               n_pronto + n_par + n_stop + log_n - b_all);
    end
    b_s = n_start;
    send_frame(7'h49, 1'b0, 1'b1);
    idle(5);
    checks++;
    if (n_start - b_s !== 1 || dado !== 7'h49) begin
      errors++;
      $display("FAIL abort_new_frame: start=%0d dado=%h want 1/49",
               n_start - b_s, dado);
    end
  endtask

  task automatic test_lowercase;
    int b_p, b_l;
    b_p = n_pronto; b_l = log_n;
    send_frame(7'h69, 1'b0, 1'b1);
    idle(5);
    checks++;
    if (n_pronto - b_p !== 1 || log_n - b_l !== 0 || dado !== 7'h69) begin
      errors++;
      $display("FAIL unknown_char: pronto=%0d cmds=%0d dado=%h want 1/0/69",
               n_pronto - b_p, log_n - b_l, dado);
    end
  endtask

  initial begin
    test_reset;
    test_start_cmd;
    test_back_to_back;
    test_parity_error;
    test_stop_error;
    test_break;
    test_glitch;
    test_lowercase;
    test_reset_mid_frame;
    checks++;
    if (n_multi !== 0) begin
      errors++;
      $display("FAIL one_hot_cmds: %0d multi-cmd cycles want 0", n_multi);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
